// File: rtl/sort8_stream_ctrl.sv
// Byte-serial streaming wrapper around the 8-input descending sorter m8.
// A frame of 8 bytes is loaded, sorted in a single cycle, then drained one
// byte per output transfer. Only one frame is in flight at a time.

// Combinational 8-input, 8-bit descending sorter (y1 largest, y8 smallest).
module m8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] d,
  input  logic [7:0] e,
  input  logic [7:0] f,
  input  logic [7:0] g,
  input  logic [7:0] h,
  output logic [7:0] y1,
  output logic [7:0] y2,
  output logic [7:0] y3,
  output logic [7:0] y4,
  output logic [7:0] y5,
  output logic [7:0] y6,
  output logic [7:0] y7,
  output logic [7:0] y8
);
  logic [7:0] v [8];
  logic [7:0] tmp;

  // Odd-even transposition network: 8 rounds fully order 8 elements.
  always_comb begin
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    v[4] = e; v[5] = f; v[6] = g; v[7] = h;
    tmp  = '0;
    for (int r = 0; r < 8; r++) begin
      for (int i = r % 2; i < 7; i += 2) begin
        if (v[i] < v[i+1]) begin
          tmp    = v[i];
          v[i]   = v[i+1];
          v[i+1] = tmp;
        end
      end
    end
  end

  assign y1 = v[0];
  assign y2 = v[1];
  assign y3 = v[2];
  assign y4 = v[3];
  assign y5 = v[4];
  assign y6 = v[5];
  assign y7 = v[6];
  assign y8 = v[7];
endmodule

// state | meaning
// LOAD  | accepting input bytes into bank slots 0..7
// SORT  | one cycle: sorter output captured from the stable bank
// DRAIN | emitting captured bytes, one per output transfer
module sort8_stream_ctrl #(
  parameter bit ASCEND = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             abort,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);
  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t     state;
  logic [2:0] load_idx;
  logic [2:0] out_idx;
  logic [7:0] bank [8];
  logic [7:0] cap  [8];
  logic [7:0] y    [8];
  logic [2:0] sel;

  m8 u_m8 (
    .a (bank[0]), .b (bank[1]), .c (bank[2]), .d (bank[3]),
    .e (bank[4]), .f (bank[5]), .g (bank[6]), .h (bank[7]),
    .y1(y[0]), .y2(y[1]), .y3(y[2]), .y4(y[3]),
    .y5(y[4]), .y6(y[5]), .y7(y[6]), .y8(y[7])
  );

  // Ascending order is just the descending capture read back to front.
  assign sel      = ASCEND ? (3'd7 - out_idx) : out_idx;
  assign out_data = out_valid ? cap[sel] : 8'd0;

  // Sequencer; handshake flags are registered alongside the state so that
  // ready/valid never depend combinationally on the opposite handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      load_idx  <= '0;
      out_idx   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
      for (int i = 0; i < 8; i++) begin
        bank[i] <= '0;
        cap[i]  <= '0;
      end
    end else if (abort) begin
      state     <= LOAD;
      load_idx  <= '0;
      out_idx   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            bank[load_idx] <= in_data;
            load_idx       <= load_idx + 3'd1;
            if (load_idx == 3'd7) begin
              state    <= SORT;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        SORT: begin
          for (int i = 0; i < 8; i++) cap[i] <= y[i];
          state     <= DRAIN;
          out_idx   <= '0;
          out_valid <= 1'b1;
          out_last  <= 1'b0;
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            if (out_idx == 3'd7) begin
              state     <= LOAD;
              out_idx   <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              frame_cnt <= frame_cnt + CNT_W'(1);
            end else begin
              out_idx  <= out_idx + 3'd1;
              out_last <= (out_idx == 3'd6);
            end
          end
        end
        default: begin
          state     <= LOAD;
          load_idx  <= '0;
          out_idx   <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sort8_stream_ctrl.sv
// Bench for sort8_stream_ctrl: a descending and an ascending instance run in
// lockstep from shared stimulus; expected bytes are queued per frame.
module tb_sort8_stream_ctrl;
  typedef logic [7:0] frame_t [8];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;
  logic        abort;

  logic        in_ready, out_valid, out_last, busy;
  logic [7:0]  out_data;
  logic [15:0] frame_cnt;

  logic        in_ready_a, out_valid_a, out_last_a, busy_a;
  logic [7:0]  out_data_a;
  logic [15:0] frame_cnt_a;

  int          total = 0;
  int          bad   = 0;
  int          exp_cnt = 0;
  logic [7:0]  q0 [$];
  logic [7:0]  q1 [$];

  always #5 clk = ~clk;

  sort8_stream_ctrl #(.ASCEND(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .abort(abort), .busy(busy),
    .frame_cnt(frame_cnt)
  );

  sort8_stream_ctrl #(.ASCEND(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_last(out_last_a), .abort(abort), .busy(busy_a),
    .frame_cnt(frame_cnt_a)
  );

  // Queue the expected descending sequence for dut and ascending for dut_a.
  task automatic push_expect(input frame_t f);
    logic [7:0] s [8];
    logic [7:0] t;
    int         m;
    for (int i = 0; i < 8; i++) s[i] = f[i];
    for (int i = 0; i < 8; i++) begin
      m = i;
      for (int k = i + 1; k < 8; k++) if (s[k] > s[m]) m = k;
      t = s[i]; s[i] = s[m]; s[m] = t;
    end
    for (int i = 0; i < 8; i++) q0.push_back(s[i]);
    for (int i = 7; i >= 0; i--) q1.push_back(s[i]);
  endtask

  // Send n_bytes of f, optionally idling gap_len cycles before byte gap_at.
  task automatic send_frame(input frame_t f, input int n_bytes,
                            input int gap_at, input int gap_len);
    int t;
    if (n_bytes == 8) push_expect(f);
    for (int i = 0; i < n_bytes; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          in_valid = 1'b0;
          total++;
          if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL gap_in_ready: got %b want 1", in_ready);
          end
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = f[i];
      t = 0;
      while (in_ready !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout: in_ready stuck low at byte %0d", i);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Drain n_xfer bytes; mode 0 always ready, 1 ready 1,0,0,..., 2 random.
  task automatic drain(input int n_xfer, input int mode);
    int         n = 0;
    int         k = 0;
    logic       holding = 1'b0;
    logic [7:0] held = '0;
    logic [7:0] e0, e1;
    while (n < n_xfer) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid === 1'b1) begin
        if (holding) begin
          total++;
          if (out_data !== held) begin
            bad++;
            $display("FAIL hold_data: got %0d want %0d", out_data, held);
          end
        end
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL drain_flags: in_ready=%b busy=%b want 0/1", in_ready, busy);
        end
        if (out_ready) begin
          if (q0.size() == 0 || q1.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: unexpected output %0d", out_data);
          end else begin
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            total++;
            if (out_data !== e0) begin
              bad++;
              $display("FAIL desc_data[%0d]: got %0d want %0d", n, out_data, e0);
            end
            total++;
            if (out_data_a !== e1) begin
              bad++;
              $display("FAIL asc_data[%0d]: got %0d want %0d", n, out_data_a, e1);
            end
            total++;
            if (out_last !== (n == 7)) begin
              bad++;
              $display("FAIL out_last[%0d]: got %b want %b", n, out_last, (n == 7));
            end
          end
          n++;
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          held    = out_data;
        end
      end
      k++;
      if (k > 200) begin
        total++;
        bad++;
        $display("FAIL drain_timeout: %0d of %0d bytes seen", n, n_xfer);
        break;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic check_idle(input string name);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        frame_cnt !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL %s: in_ready=%b out_valid=%b busy=%b frame_cnt=%0d want 1/0/0/%0d",
               name, in_ready, out_valid, busy, frame_cnt, exp_cnt);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    q0.delete();
    q1.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0 ||
        out_last !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b out_data=%0d out_last=%b busy=%b cnt=%0d",
               in_ready, out_valid, out_data, out_last, busy, frame_cnt);
    end
    rst_n = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    frame_t f = '{8'd3, 8'd200, 8'd17, 8'd200, 8'd0, 8'd255, 8'd9, 8'd128};
    send_frame(f, 8, -1, 0);
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL sort_cycle: out_valid=%b busy=%b in_ready=%b want 0/1/0",
               out_valid, busy, in_ready);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL latency: out_valid=%b want 1 two cycles after last byte", out_valid);
    end
    drain(8, 0);
    exp_cnt++;
    check_idle("basic_end");
  endtask

  task automatic test_backpressure();
    frame_t f = '{8'd3, 8'd200, 8'd17, 8'd200, 8'd0, 8'd255, 8'd9, 8'd128};
    send_frame(f, 8, -1, 0);
    drain(8, 1);
    exp_cnt++;
    check_idle("backpressure_end");
  endtask

  task automatic test_gapped();
    frame_t f = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2};
    send_frame(f, 8, 4, 3);
    drain(8, 0);
    exp_cnt++;
    check_idle("gapped_end");
  endtask

  task automatic test_ascend();
    frame_t f = '{8'd10, 8'd50, 8'd30, 8'd20, 8'd80, 8'd70, 8'd60, 8'd40};
    send_frame(f, 8, -1, 0);
    drain(8, 2);
    exp_cnt++;
    check_idle("ascend_end");
  endtask

  task automatic test_abort();
    frame_t junk = '{8'd90, 8'd91, 8'd92, 8'd93, 8'd94, 8'd95, 8'd96, 8'd97};
    frame_t f    = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    frame_t r;
    apply_reset();
    send_frame(junk, 5, -1, 0);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd99;
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    check_idle("abort_load");
    send_frame(f, 8, -1, 0);
    drain(8, 0);
    exp_cnt++;
    check_idle("abort_load_end");
    total++;
    if (frame_cnt !== 16'd1) begin
      bad++;
      $display("FAIL abort_frame_cnt: got %0d want 1", frame_cnt);
    end
    // Abort during DRAIN after three bytes have left.
    for (int i = 0; i < 8; i++) r[i] = 8'($urandom_range(0, 255));
    send_frame(r, 8, -1, 0);
    drain(3, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    q0.delete();
    q1.delete();
    total++;
    if (out_last !== 1'b0) begin
      bad++;
      $display("FAIL abort_drain_last: got %b want 0", out_last);
    end
    check_idle("abort_drain");
    for (int i = 0; i < 8; i++) r[i] = 8'($urandom_range(0, 255));
    send_frame(r, 8, -1, 0);
    drain(8, 0);
    exp_cnt++;
    check_idle("abort_recover");
  endtask

  task automatic test_async_reset();
    frame_t f  = '{8'd40, 8'd4, 8'd44, 8'd14, 8'd24, 8'd34, 8'd54, 8'd64};
    frame_t ff = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_frame(f, 8, -1, 0);
    drain(4, 0);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL async_reset: out_valid=%b in_ready=%b frame_cnt=%0d want 0/1/0",
               out_valid, in_ready, frame_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q0.delete();
    q1.delete();
    @(negedge clk);
    send_frame(ff, 8, -1, 0);
    drain(8, 0);
    exp_cnt++;
    check_idle("after_reset_frame");
  endtask

  task automatic test_back_to_back();
    frame_t r;
    for (int fr = 0; fr < 3; fr++) begin
      for (int i = 0; i < 8; i++) r[i] = 8'($urandom_range(0, 15));
      send_frame(r, 8, -1, 0);
      drain(8, 2);
      exp_cnt++;
    end
    check_idle("back_to_back_end");
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    abort     = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_ascend();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
